// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use stall detection and EX operand forwarding for a 5-stage pipeline.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   id_*                  ID-stage instruction fields (valid, sources, use flags, rd, control bits)
//   flush                 taken branch in EX; kills the instruction entering EX
//   ex_rs1/rs2_data       ID/EX-latched register-file operands
//   mem_alu_result        EX/MEM ALU result (MEM forward source)
//   wb_data               MEM/WB write-back value (WB forward source)
//   stall                 hold PC and IF/ID, bubble into ID/EX
//   fwd_a, fwd_b          operand source: 00 regfile, 01 MEM, 10 WB
//   ex_op_a, ex_op_b      forwarded EX operands
//   stall_cnt, flush_cnt  saturating event counters, present only with HAZ_STATS_EN defined
module hazard_fwd_unit #(
   parameter int XLEN = 8,
   parameter int REGW = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic            id_rs1_used,
   input  logic            id_rs2_used,
   input  logic [REGW-1:0] id_rd,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            flush,
   input  logic [XLEN-1:0] ex_rs1_data,
   input  logic [XLEN-1:0] ex_rs2_data,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [XLEN-1:0] wb_data,
   output logic            stall,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b,
   output logic [XLEN-1:0] ex_op_a,
   output logic [XLEN-1:0] ex_op_b
`ifdef HAZ_STATS_EN
   ,
   output logic [CNTW-1:0] stall_cnt,
   output logic [CNTW-1:0] flush_cnt
`endif
);
   typedef struct packed {
      logic            v;
      logic [REGW-1:0] rd;
      logic            rw;
      logic            mr;
      logic [REGW-1:0] rs1;
      logic [REGW-1:0] rs2;
      logic            u1;
      logic            u2;
   } ex_t;
   typedef struct packed {
      logic            v;
      logic [REGW-1:0] rd;
      logic            rw;
      logic            mr;
   } mem_t;
   // memread is dead once the instruction reaches WB, so WB keeps only what forwarding needs
   typedef struct packed {
      logic            v;
      logic [REGW-1:0] rd;
      logic            rw;
   } wb_t;
   ex_t  ex;
   mem_t mem;
   wb_t  wb;
   logic mem_src, wb_src;
   logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ex  <= '0;
         mem <= '0;
         wb  <= '0;
      end else begin
         wb  <= '{v: mem.v, rd: mem.rd, rw: mem.rw};
         mem <= '{v: ex.v, rd: ex.rd, rw: ex.rw, mr: ex.mr};
         ex  <= (flush || stall) ? '0 :
                '{v: id_valid, rd: id_rd, rw: id_regwrite, mr: id_memread,
                  rs1: id_rs1, rs2: id_rs2, u1: id_rs1_used, u2: id_rs2_used};
      end
   // flush outranks the load-use condition: the stalled-for producer is being killed anyway
   always_comb
      stall = id_valid && ex.v && ex.mr && ex.rw && (ex.rd != '0) && !flush &&
              ((id_rs1_used && id_rs1 == ex.rd) || (id_rs2_used && id_rs2 == ex.rd));
   // an invalid EX entry gates every hit, so a bubble never forwards
   always_comb begin
      mem_src   = ex.v && mem.v && mem.rw && (mem.rd != '0);
      wb_src    = ex.v && wb.v && wb.rw && (wb.rd != '0);
      mem_hit_a = mem_src && ex.u1 && mem.rd == ex.rs1;
      mem_hit_b = mem_src && ex.u2 && mem.rd == ex.rs2;
      wb_hit_a  = wb_src && ex.u1 && wb.rd == ex.rs1;
      wb_hit_b  = wb_src && ex.u2 && wb.rd == ex.rs2;
   end
   // a load matching in MEM must not fall through to an older WB value; it yields 00
   always_comb begin
      fwd_a = mem_hit_a ? (mem.mr ? 2'b00 : 2'b01) : wb_hit_a ? 2'b10 : 2'b00;
      fwd_b = mem_hit_b ? (mem.mr ? 2'b00 : 2'b01) : wb_hit_b ? 2'b10 : 2'b00;
   end
   always_comb begin
      ex_op_a = (fwd_a == 2'b01) ? mem_alu_result : (fwd_a == 2'b10) ? wb_data : ex_rs1_data;
      ex_op_b = (fwd_b == 2'b01) ? mem_alu_result : (fwd_b == 2'b10) ? wb_data : ex_rs2_data;
   end
   load_in_mem_fwd: assert property (@(posedge clk) disable iff (!reset)
      !((mem_hit_a || mem_hit_b) && mem.mr))
      else $error("load in MEM matched an EX source; load-use stall was bypassed");
`ifdef HAZ_STATS_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      end
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed scoreboard bench for hazard_fwd_unit.
module tb_hazard_fwd_unit;
   localparam int XLEN = 8;
   localparam int REGW = 5;
   // narrow counters so saturation is reachable in a few dozen cycles
   localparam int CW = 4;
   localparam logic [7:0] RS1D = 8'h11, RS2D = 8'h22, MEMD = 8'h2A, WBD = 8'h5C;
   logic            clk = 1'b0;
   logic            reset;
   logic            id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread, flush;
   logic [REGW-1:0] id_rs1, id_rs2, id_rd;
   logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, mem_alu_result, wb_data;
   logic            stall;
   logic [1:0]      fwd_a, fwd_b;
   logic [XLEN-1:0] ex_op_a, ex_op_b;
`ifdef HAZ_STATS_EN
   logic [CW-1:0]   stall_cnt, flush_cnt;
`endif
   int vectors = 0;
   int errors = 0;
   typedef struct {
      string      tag;
      logic       st;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [7:0] oa;
      logic [7:0] ob;
   } exp_t;
   exp_t sb[$];
   hazard_fwd_unit #(.XLEN(XLEN), .REGW(REGW), .CNTW(CW)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .mem_alu_result(mem_alu_result), .wb_data(wb_data),
      .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b)
`ifdef HAZ_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic set_id(input logic v, input int r1, input logic u1, input int r2, input logic u2,
                         input int rd, input logic rw, input logic mr);
      id_valid = v; id_rs1 = REGW'(r1); id_rs1_used = u1; id_rs2 = REGW'(r2); id_rs2_used = u2;
      id_rd = REGW'(rd); id_regwrite = rw; id_memread = mr;
   endtask
   // an invalid slot whose fields would match x3 if validity were ignored
   task automatic nop();
      set_id(1'b0, 3, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
   endtask
   task automatic exp(input string tag, input logic st, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [7:0] oa, input logic [7:0] ob);
      exp_t e;
      e.tag = tag; e.st = st; e.fa = fa; e.fb = fb; e.oa = oa; e.ob = ob;
      sb.push_back(e);
   endtask
   task automatic cmp();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".stall"}, 32'(stall), 32'(e.st));
      chk({e.tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
      chk({e.tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
      chk({e.tag, ".op_a"}, 32'(ex_op_a), 32'(e.oa));
      chk({e.tag, ".op_b"}, 32'(ex_op_b), 32'(e.ob));
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic run(input string tag, input logic st, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [7:0] oa, input logic [7:0] ob);
      exp(tag, st, fa, fb, oa, ob);
      @(negedge clk);
      cmp();
      tick();
   endtask
   initial begin
      reset = 1'b0; flush = 1'b0;
      ex_rs1_data = RS1D; ex_rs2_data = RS2D; mem_alu_result = MEMD; wb_data = WBD;
      set_id(1'b1, 6, 1'b1, 6, 1'b1, 7, 1'b1, 1'b0);
      tick(); tick();
      run("reset", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
`ifdef HAZ_STATS_EN
      chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
      chk("reset.flush_cnt", 32'(flush_cnt), 32'd0);
`endif
      reset = 1'b1;
      set_id(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
      run("add_x3", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 3, 1'b1, 4, 1'b1, 5, 1'b1, 1'b0);
      run("sub_in_id", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      nop();
      run("mem_fwd", 1'b0, 2'b01, 2'b00, MEMD, RS2D);
      nop();
      run("ex_invalid", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b1);
      run("lw_x6", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 6, 1'b1, 6, 1'b1, 7, 1'b1, 1'b0);
      run("load_use", 1'b1, 2'b00, 2'b00, RS1D, RS2D);
      run("bubble", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      nop();
      run("wb_fwd_ab", 1'b0, 2'b10, 2'b10, WBD, WBD);
`ifdef HAZ_STATS_EN
      chk("stall_cnt_one", 32'(stall_cnt), 32'd1);
`endif
      set_id(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
      run("dbl_add", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
      run("dbl_or", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 3, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0);
      run("dbl_sub_id", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      nop();
      run("mem_over_wb", 1'b0, 2'b01, 2'b00, MEMD, RS2D);
      set_id(1'b1, 1, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0);
      run("wr_x0", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 0, 1'b1, 0, 1'b1, 9, 1'b1, 1'b0);
      run("rd_x0_id", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      nop();
      run("x0_no_fwd", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 4, 1'b1, 9, 1'b1, 11, 1'b1, 1'b0);
      run("add_x11", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      nop();
      run("wb_fwd_b", 1'b0, 2'b00, 2'b10, RS1D, WBD);
      set_id(1'b1, 1, 1'b1, 0, 1'b0, 12, 1'b1, 1'b1);
      run("lw_x12", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 1, 1'b1, 12, 1'b0, 13, 1'b1, 1'b0);
      run("rs2_unused", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      nop();
      run("load_mem_unused", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b1);
      run("lw_x6_b", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 6, 1'b1, 6, 1'b1, 7, 1'b1, 1'b0);
      flush = 1'b1;
      run("flush_vs_stall", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      flush = 1'b0;
`ifdef HAZ_STATS_EN
      chk("flush_cnt_one", 32'(flush_cnt), 32'd1);
`endif
      nop();
      run("flushed_ex", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b1);
      run("lw_x6_c", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 6, 1'b1, 6, 1'b1, 7, 1'b1, 1'b0);
      exp("pre_reset_stall", 1'b1, 2'b00, 2'b00, RS1D, RS2D);
      @(negedge clk);
      cmp();
      reset = 1'b0;
      exp("async_reset", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      #1;
      cmp();
`ifdef HAZ_STATS_EN
      chk("async_reset.stall_cnt", 32'(stall_cnt), 32'd0);
      chk("async_reset.flush_cnt", 32'(flush_cnt), 32'd0);
`endif
      tick();
      reset = 1'b1;
      run("post_reset_id", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      nop();
      run("post_reset_ex", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 1, 1'b1, 0, 1'b0, 14, 1'b1, 1'b1);
      run("lw_x14", 1'b0, 2'b00, 2'b00, RS1D, RS2D);
      set_id(1'b1, 1, 1'b1, 14, 1'b1, 0, 1'b0, 1'b0);
      run("load_use_rs2", 1'b1, 2'b00, 2'b00, RS1D, RS2D);
      nop();
      tick();
`ifdef HAZ_STATS_EN
      for (int i = 0; i < 20; i++) begin
         set_id(1'b1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b1);
         tick();
         set_id(1'b1, 6, 1'b1, 6, 1'b1, 7, 1'b1, 1'b0);
         tick();
         tick();
      end
      chk("stall_cnt_sat", 32'(stall_cnt), 32'((1 << CW) - 1));
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit
Interface
REQ-001 Parameter XLEN, 8, data width of the forwarded operands.
REQ-002 Parameter REGW, 5, register-address width; register 0 is hard-zero and is never a hazard source.
REQ-003 Parameter CNTW, 16, statistics counter width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 id_valid  in  1  the ID stage holds a real instruction.
REQ-007 id_rs1 / id_rs2  in  REGW each (two ports)  ID-stage source registers.
REQ-008 id_rs1_used / id_rs2_used  in  1 each (two ports)  the source is actually read; 0 for I-type rs2, LUI and similar.
REQ-009 id_rd  in  REGW  ID-stage destination register.
REQ-010 id_regwrite / id_memread  in  1 each (two ports)  ID-stage control bits from the control unit.
REQ-011 flush  in  1  a branch resolved taken in EX; kills the instruction entering EX.
REQ-012 ex_rs1_data / ex_rs2_data  in  XLEN each (two ports)  ID/EX-latched register-file operands.
REQ-013 mem_alu_result  in  XLEN  EX/MEM ALU result.
REQ-014 wb_data  in  XLEN  MEM/WB write-back mux output.
REQ-015 stall  out  1  hold the PC and IF/ID; insert a bubble into ID/EX.
REQ-016 fwd_a / fwd_b  out  2 each (two ports)  operand source: 00 register file, 01 MEM stage, 10 WB stage.
REQ-017 ex_op_a / ex_op_b  out  XLEN each (two ports)  forwarded EX operands that feed the ALU and the ALUSrc mux.
REQ-018 stall_cnt / flush_cnt  out  CNTW each (two ports)  present only when HAZ_STATS_EN is defined.
Function
REQ-019 The block SHALL keep shadow entries EX, MEM and WB.
- Each entry holds {valid, rd, regwrite, memread}.
- The EX entry also holds {rs1, rs2, rs1_used, rs2_used}.
REQ-020 On each clock edge: WB<=MEM and MEM<=EX.
- EX<=invalid if flush=1 or stall=1.
- Otherwise EX<=the ID fields, with valid=id_valid.
REQ-021 Load-use hazard: stall SHALL be 1 when all of the following hold, and 0 otherwise:
- id_valid, EX.valid, EX.memread, EX.regwrite and EX.rd!=0;
- the stall is not suppressed by flush (flush=0);
- (id_rs1_used and id_rs1==EX.rd) or (id_rs2_used and id_rs2==EX.rd).
REQ-022 stall SHALL be combinational from the registered entries and the ID inputs, with no added latency.
REQ-023 fwd_a SHALL select its source as follows:
- 01 if MEM.valid, MEM.regwrite, MEM.rd!=0, EX.rs1_used and MEM.rd==EX.rs1;
- else 10 under the same conditions against WB;
- else 00.
- fwd_b SHALL follow the same rules using rs2.
REQ-024 MEM SHALL take priority over WB when both match, so the youngest producer wins.
REQ-025 A load in MEM SHALL never produce a fwd value of 01.
- The load-use stall guarantees this.
- If it is violated, the block SHALL output 00 and assert a simulation-only $error.
REQ-026 ex_op_a/ex_op_b SHALL be combinational muxes selected by fwd_a/fwd_b.
- Select code 11 is unreachable and SHALL yield the register-file value.
REQ-027 If flush and the stall condition are both true, flush SHALL win: stall=0 and EX becomes invalid.
REQ-028 When EX is invalid, fwd_a and fwd_b SHALL both be 00.
Reset
REQ-029 While reset=0, all of the following SHALL hold asynchronously:
- every entry is invalid with its fields at 0;
- stall=0, fwd_a=fwd_b=00;
- the counters are 0;
- ex_op_a/ex_op_b follow ex_rs1_data/ex_rs2_data.
REQ-030 On reset release mid-program, no stall or forward SHALL be asserted until new entries propagate into the shadow stages.
Configuration
REQ-031 With HAZ_STATS_EN defined:
- stall_cnt SHALL increment on each edge where stall=1;
- flush_cnt SHALL increment on each edge where flush=1;
- both counters SHALL saturate at all ones.
REQ-032 Without HAZ_STATS_EN, neither the counter ports nor the counter logic SHALL exist; all other behaviour is identical.
Verification
REQ-033 ALU result forwarded from MEM: add x3 then, back-to-back, sub x5,x3,x4; x3 result=8'h2A -> with sub in EX, fwd_a=01 and ex_op_a=8'h2A.
REQ-034 Load-use stall: lw x6 then, back-to-back, add x7,x6,x6 -> stall=1 for exactly one cycle, and the next cycle has fwd_a=fwd_b=10 with ex_op=wb_data.
REQ-035 Double producer: add x3 then or x3 then sub x8,x3,x0 -> MEM wins, fwd_a=01 and fwd_b=00 (x0 never forwards).
REQ-036 Flush vs stall: a load-use condition with flush=1 in the same cycle -> stall=0, EX invalid next cycle, and flush_cnt increments by 1.
REQ-037 Reset mid-stream: reset=0 during a load-use stall -> stall falls immediately, fwd=00, and the counters are 0.
REQ-038 Counter saturation: stall_cnt preset to 16'hFFFF, then a stall occurs -> stall_cnt stays 16'hFFFF.
